pipe_hazard_ctrl: RTL and testbench

Central hazard and stall controller for the 5-stage RV32I pipeline. It drives the enabler and active-low sync_reset (flush) inputs of the F/D/E/M/W pipe registers, and generates the E-stage forwarding selects from the Rs1_E/Rs2_E/Rd fields those registers carry. It also owns the data-memory wait FSM, with timeout, and a stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_fwd_unit.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and index constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  localparam int NUM_STG = 5;
  localparam int STG_F   = 0;
  localparam int STG_D   = 1;
  localparam int STG_E   = 2;
  localparam int STG_M   = 3;
  localparam int STG_W   = 4;

  localparam int FLS_D   = 0;
  localparam int FLS_E   = 1;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Combinational E-stage operand forwarding select; the M-stage result is younger so it wins over W.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rd_m,
  input  logic                  i_reg_write_m,
  input  logic [REG_ADDR_W-1:0] i_rd_w,
  input  logic                  i_reg_write_w,
  output fwd_sel_t              o_sel
);

  logic w_hit_m;
  logic w_hit_w;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  assign w_hit_m = i_reg_write_m && (i_rd_m != '0) && (i_rd_m == i_rs);
  assign w_hit_w = i_reg_write_w && (i_rd_w != '0) && (i_rd_w == i_rs);

  always_comb begin
    o_sel = FWD_REG;
    if (w_hit_m) begin
      o_sel = FWD_M;
    end else if (w_hit_w) begin
      o_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: pipe-register enables and flushes, forwarding selects,
// data-memory wait FSM with sticky timeout error, saturating stall-cycle counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W     = 5,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STALL_CNT_W    = 32
) (
  input  logic                   clock,
  input  logic                   async_reset,
  input  logic [REG_ADDR_W-1:0]  Rs1_D,
  input  logic [REG_ADDR_W-1:0]  Rs2_D,
  input  logic [REG_ADDR_W-1:0]  Rd_E,
  input  logic [REG_ADDR_W-1:0]  Rs1_E,
  input  logic [REG_ADDR_W-1:0]  Rs2_E,
  input  logic                   mem_read_E,
  input  logic                   branch_taken_E,
  input  logic [REG_ADDR_W-1:0]  Rd_M,
  input  logic                   reg_write_M,
  input  logic                   mem_req_M,
  input  logic                   mem_ack,
  input  logic [REG_ADDR_W-1:0]  Rd_W,
  input  logic                   reg_write_W,
  output logic [NUM_STG-1:0]     stage_en,
  output logic [1:0]             flush_n,
  output logic [1:0]             fwd_A_E,
  output logic [1:0]             fwd_B_E,
  output logic                   mem_error,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t            r_state;
  ctrl_state_t            w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [STALL_CNT_W-1:0] r_stall;
  logic                   w_frozen;
  logic                   w_cnt_clr;
  logic                   w_cnt_inc;
  logic                   w_load_use;
  fwd_sel_t               w_fwd_a;
  fwd_sel_t               w_fwd_b;

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_frozen  = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (mem_req_M && !mem_ack) begin
          w_frozen  = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_inc = 1'b1;
        if (mem_ack) begin
          w_next = ST_RUN;
        end else begin
          w_frozen = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_next = ST_ERROR;
          end
        end
      end
      ST_ERROR: begin
        w_frozen = 1'b1;
      end
      default: begin
        w_frozen = 1'b1;
        w_next   = ST_ERROR;
      end
    endcase
  end

  assign w_load_use = mem_read_E && (Rd_E != '0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

  // The ack cycle is the first unfrozen cycle, so hazards held by the frozen
  // registers are resolved there rather than being carried past unseen.
  always_comb begin
    stage_en = '1;
    flush_n  = 2'b11;
    if (w_frozen) begin
      stage_en = '0;
    end else if (branch_taken_E) begin
      flush_n[FLS_D] = 1'b0;
      flush_n[FLS_E] = 1'b0;
    end else if (w_load_use) begin
      stage_en[STG_F] = 1'b0;
      stage_en[STG_D] = 1'b0;
      flush_n[FLS_E]  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      r_stall <= '0;
    end else if (!stage_en[STG_F] && !(&r_stall)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
  assign mem_error    = (r_state == ST_ERROR);

  pipe_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_rs          (Rs1_E),
    .i_rd_m        (Rd_M),
    .i_reg_write_m (reg_write_M),
    .i_rd_w        (Rd_W),
    .i_reg_write_w (reg_write_W),
    .o_sel         (w_fwd_a)
  );

  pipe_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_rs          (Rs2_E),
    .i_rd_m        (Rd_M),
    .i_reg_write_m (reg_write_M),
    .i_rd_w        (Rd_W),
    .i_reg_write_w (reg_write_W),
    .o_sel         (w_fwd_b)
  );

  assign fwd_A_E = w_fwd_a;
  assign fwd_B_E = w_fwd_b;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int RW      = 5;
  localparam int TIMEOUT = 64;
  localparam int SW      = 32;

  logic          clock = 1'b0;
  logic          async_reset = 1'b0;
  logic [RW-1:0] Rs1_D, Rs2_D, Rd_E, Rs1_E, Rs2_E, Rd_M, Rd_W;
  logic          mem_read_E, branch_taken_E, reg_write_M, mem_req_M, mem_ack, reg_write_W;
  logic [4:0]    stage_en;
  logic [1:0]    flush_n, fwd_A_E, fwd_B_E;
  logic          mem_error;
  logic [SW-1:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 = running, 1 = waiting on memory, 2 = dead until reset.
  int            m_mode = 0;
  int            m_waited = 0;
  logic [SW-1:0] m_stall = '0;

  pipe_hazard_ctrl #(.REG_ADDR_W(RW), .TIMEOUT_CYCLES(TIMEOUT), .STALL_CNT_W(SW)) dut (
    .clock(clock), .async_reset(async_reset),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_E(Rd_E), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
    .mem_read_E(mem_read_E), .branch_taken_E(branch_taken_E),
    .Rd_M(Rd_M), .reg_write_M(reg_write_M), .mem_req_M(mem_req_M), .mem_ack(mem_ack),
    .Rd_W(Rd_W), .reg_write_W(reg_write_W),
    .stage_en(stage_en), .flush_n(flush_n), .fwd_A_E(fwd_A_E), .fwd_B_E(fwd_B_E),
    .mem_error(mem_error), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] rs);
    if (reg_write_M && Rd_M != 0 && Rd_M == rs) return 2'b10;
    if (reg_write_W && Rd_W != 0 && Rd_W == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic ref_frozen();
    if (m_mode == 2) return 1'b1;
    if (m_mode == 1) return !mem_ack;
    return mem_req_M && !mem_ack;
  endfunction

  function automatic logic [6:0] ref_ctrl();  // {stage_en, flush_n}
    if (ref_frozen()) return {5'b00000, 2'b11};
    if (branch_taken_E) return {5'b11111, 2'b00};
    if (mem_read_E && Rd_E != 0 && (Rd_E == Rs1_D || Rd_E == Rs2_D)) return {5'b11100, 2'b01};
    return {5'b11111, 2'b11};
  endfunction

  always @(posedge clock or negedge async_reset) begin
    if (!async_reset) begin
      m_mode = 0; m_waited = 0; m_stall = '0;
    end else begin
      logic [6:0] c;
      c = ref_ctrl();
      if (c[2] == 1'b0 && m_stall != '1) m_stall = m_stall + 1;
      if (m_mode == 0 && mem_req_M && !mem_ack) begin
        m_mode = 1; m_waited = 0;
      end else if (m_mode == 1) begin
        m_waited = m_waited + 1;
        if (mem_ack) m_mode = 0;
        else if (m_waited == TIMEOUT) m_mode = 2;
      end
    end
  end

  task automatic idle();
    Rs1_D = 0; Rs2_D = 0; Rd_E = 0; Rs1_E = 0; Rs2_E = 0; Rd_M = 0; Rd_W = 0;
    mem_read_E = 0; branch_taken_E = 0; reg_write_M = 0; mem_req_M = 0; mem_ack = 0; reg_write_W = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle();
    async_reset = 1'b0;
    #2 async_reset = 1'b1;
  endtask

  task automatic drive_next();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    checks++; if (stage_en !== 5'b11111) begin errors++; $display("FAIL reset_stage_en got=%b exp=11111", stage_en); end
    checks++; if (flush_n !== 2'b11) begin errors++; $display("FAIL reset_flush_n got=%b exp=11", flush_n); end
    checks++; if (fwd_A_E !== 2'b00 || fwd_B_E !== 2'b00) begin errors++; $display("FAIL reset_fwd got=%b/%b exp=00/00", fwd_A_E, fwd_B_E); end
    checks++; if (stall_cycles !== 0 || mem_error !== 1'b0) begin errors++; $display("FAIL reset_counters stall=%0d err=%b exp=0/0", stall_cycles, mem_error); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_next();
    mem_read_E = 1; Rd_E = 5; Rs1_D = 5;
    @(negedge clock);
    checks++; if (stage_en !== 5'b11100 || flush_n !== 2'b01) begin errors++; $display("FAIL load_use got en=%b fl=%b exp 11100/01", stage_en, flush_n); end
    drive_next();
    Rd_E = 9; Rs1_D = 3; Rs2_D = 9;
    @(negedge clock);
    checks++; if (stage_en !== 5'b11100 || flush_n !== 2'b01) begin errors++; $display("FAIL load_use_rs2 got en=%b fl=%b exp 11100/01", stage_en, flush_n); end
    drive_next();
    Rd_E = 0; Rs1_D = 0; Rs2_D = 0;
    @(negedge clock);
    checks++; if (stage_en !== 5'b11111 || flush_n !== 2'b11) begin errors++; $display("FAIL load_use_x0 got en=%b fl=%b exp 11111/11", stage_en, flush_n); end
    checks++; if (stall_cycles !== 2) begin errors++; $display("FAIL load_use_stalls got=%0d exp=2", stall_cycles); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    drive_next();
    mem_read_E = 1; Rd_E = 4; Rs2_D = 4; branch_taken_E = 1;
    @(negedge clock);
    checks++; if (stage_en !== 5'b11111 || flush_n !== 2'b00) begin errors++; $display("FAIL branch_wins got en=%b fl=%b exp 11111/00", stage_en, flush_n); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive_next();
    mem_req_M = 1; mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++; if (stage_en !== 5'b00000 || flush_n !== 2'b11) begin errors++; $display("FAIL mem_wait_freeze cyc=%0d got en=%b fl=%b exp 00000/11", i, stage_en, flush_n); end
      drive_next();
    end
    mem_ack = 1;
    @(negedge clock);
    checks++; if (stage_en !== 5'b11111) begin errors++; $display("FAIL mem_wait_ack got en=%b exp 11111", stage_en); end
    drive_next();
    mem_req_M = 0; mem_ack = 0;
    @(negedge clock);
    checks++; if (stall_cycles !== 3 || stage_en !== 5'b11111) begin errors++; $display("FAIL mem_wait_after got stall=%0d en=%b exp 3/11111", stall_cycles, stage_en); end
  endtask

  task automatic test_timeout();
    do_reset();
    drive_next();
    mem_req_M = 1; mem_ack = 0;
    for (int i = 0; i < TIMEOUT; i++) drive_next();
    @(negedge clock);
    checks++; if (mem_error !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", mem_error); end
    drive_next();
    @(negedge clock);
    checks++; if (mem_error !== 1'b1) begin errors++; $display("FAIL timeout_set got=%b exp=1", mem_error); end
    drive_next();
    mem_ack = 1; mem_req_M = 0;
    @(negedge clock);
    checks++; if (mem_error !== 1'b1 || stage_en !== 5'b00000) begin errors++; $display("FAIL timeout_sticky got err=%b en=%b exp 1/00000", mem_error, stage_en); end
    do_reset();
    @(negedge clock);
    checks++; if (mem_error !== 1'b0 || stage_en !== 5'b11111) begin errors++; $display("FAIL timeout_reset got err=%b en=%b exp 0/11111", mem_error, stage_en); end
  endtask

  task automatic test_forwarding();
    do_reset();
    drive_next();
    Rs1_E = 7; Rs2_E = 7; Rd_M = 7; reg_write_M = 1; Rd_W = 7; reg_write_W = 1;
    @(negedge clock);
    checks++; if (fwd_A_E !== 2'b10 || fwd_B_E !== 2'b10) begin errors++; $display("FAIL fwd_m_wins got=%b/%b exp 10/10", fwd_A_E, fwd_B_E); end
    reg_write_M = 0;
    #1;
    checks++; if (fwd_A_E !== 2'b01) begin errors++; $display("FAIL fwd_w got=%b exp 01", fwd_A_E); end
    Rs1_E = 0; Rd_W = 0; Rs2_E = 3;
    #1;
    checks++; if (fwd_A_E !== 2'b00 || fwd_B_E !== 2'b00) begin errors++; $display("FAIL fwd_x0 got=%b/%b exp 00/00", fwd_A_E, fwd_B_E); end
  endtask

  task automatic test_random();
    logic [6:0] c;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive_next();
      Rs1_D = RW'($urandom_range(0, 3)); Rs2_D = RW'($urandom_range(0, 3));
      Rd_E  = RW'($urandom_range(0, 3)); Rs1_E = RW'($urandom_range(0, 3));
      Rs2_E = RW'($urandom_range(0, 3)); Rd_M  = RW'($urandom_range(0, 3));
      Rd_W  = RW'($urandom_range(0, 3));
      mem_read_E     = ($urandom_range(0, 2) == 0);
      branch_taken_E = ($urandom_range(0, 5) == 0);
      reg_write_M    = $urandom_range(0, 1) != 0;
      reg_write_W    = $urandom_range(0, 1) != 0;
      mem_req_M      = ($urandom_range(0, 7) == 0);
      mem_ack        = ($urandom_range(0, 2) == 0);
      @(negedge clock);
      c = ref_ctrl();
      checks++;
      if (stage_en !== c[6:2] || flush_n !== c[1:0]) begin
        errors++; $display("FAIL rand_ctrl n=%0d got en=%b fl=%b exp en=%b fl=%b", n, stage_en, flush_n, c[6:2], c[1:0]);
      end
      checks++;
      if (fwd_A_E !== ref_fwd(Rs1_E) || fwd_B_E !== ref_fwd(Rs2_E)) begin
        errors++; $display("FAIL rand_fwd n=%0d got=%b/%b exp=%b/%b", n, fwd_A_E, fwd_B_E, ref_fwd(Rs1_E), ref_fwd(Rs2_E));
      end
      checks++;
      if (stall_cycles !== m_stall || mem_error !== (m_mode == 2)) begin
        errors++; $display("FAIL rand_state n=%0d got stall=%0d err=%b exp stall=%0d err=%b", n, stall_cycles, mem_error, m_stall, (m_mode == 2));
      end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_forwarding();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
